// File: rtl/qpsk_symbol_mux.sv
// QPSK symbol mux: packs serial bit pairs into a 4-deep symbol FIFO and, at each carrier-period boundary,
// selects one of four phase-shifted carrier samples. The output is registered (1 cycle after the q inputs); bit_ready drops while the FIFO is full.
module qpsk_symbol_mux (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       phase_zero,
  input  logic [7:0] q00_in,
  input  logic [7:0] q01_in,
  input  logic [7:0] q10_in,
  input  logic [7:0] q11_in,
  output logic [7:0] mod_out,
  output logic       mod_valid,
  output logic       sym_start,
  output logic       underrun
);

  localparam logic [7:0] MIDSCALE = 8'd100;

  logic [3:0] phase_cnt;
  logic [1:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       half, msb;
  logic [1:0] cur_sym;
  logic       active;

  logic       boundary, pop, accept, push, active_nxt;
  logic [1:0] head, sel_sym;
  logic [7:0] sample;

  assign bit_ready = (count < 3'd4);
  assign accept    = bit_valid && bit_ready;
  assign push      = accept && half;
  assign boundary  = phase_zero || (phase_cnt == 4'd0);
  // Pop looks only at the registered count, so a same-cycle push into an empty FIFO is not seen.
  assign pop       = boundary && (count != 3'd0);
  assign head      = fifo_mem[rd_ptr];
  assign sel_sym   = pop ? head : cur_sym;
  assign active_nxt = boundary ? pop : active;

  always_comb begin
    sample = MIDSCALE;
    case (sel_sym)
      2'b00: sample = q00_in;
      2'b01: sample = q01_in;
      2'b10: sample = q10_in;
      2'b11: sample = q11_in;
      default: sample = MIDSCALE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {msb, bit_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= 4'd0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
      half      <= 1'b0;
      msb       <= 1'b0;
      cur_sym   <= 2'b00;
      active    <= 1'b0;
      mod_out   <= MIDSCALE;
      mod_valid <= 1'b0;
      sym_start <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      phase_cnt <= phase_zero ? 4'd1 : phase_cnt + 4'd1;

      if (accept) begin
        if (half) begin
          half <= 1'b0;
        end else begin
          msb  <= bit_in;
          half <= 1'b1;
        end
      end

      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (pop) cur_sym <= head;
      active    <= active_nxt;
      mod_out   <= active_nxt ? sample : MIDSCALE;
      mod_valid <= active_nxt;
      sym_start <= pop;
      underrun  <= boundary && (count == 3'd0) && active;
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_mux.sv
// Bench for qpsk_symbol_mux: directed scenarios plus random traffic against a queue-based model.
module tb_qpsk_symbol_mux;

  logic       clk = 1'b0;
  logic       rst, bit_in, bit_valid, bit_ready, phase_zero;
  logic [7:0] q00, q01, q10, q11;
  logic [7:0] mod_out;
  logic       mod_valid, sym_start, underrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       m_phase;
  bit [1:0] m_fifo [$];
  bit       m_half, m_msb, m_active;
  bit [1:0] m_cur;

  always #5 clk = ~clk;

  qpsk_symbol_mux dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .phase_zero(phase_zero), .q00_in(q00), .q01_in(q01), .q10_in(q10), .q11_in(q11),
    .mod_out(mod_out), .mod_valid(mod_valid), .sym_start(sym_start), .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qsel(input bit [1:0] s);
    case (s)
      2'b00: return q00;
      2'b01: return q01;
      2'b10: return q10;
      default: return q11;
    endcase
  endfunction

  // One clock: drive inputs, check bit_ready, advance the model, then check registered outputs.
  task automatic cycle(input bit r, input bit bv, input bit bi, input bit pz);
    bit       bnd, pop, ur, act_n;
    bit [1:0] sel;
    int       sz;
    logic [7:0] e_mod;
    rst = r; bit_valid = bv; bit_in = bi; phase_zero = pz;
    #1;
    sz = m_fifo.size();
    chk("bit_ready", bit_ready, (sz < 4));
    if (r) begin
      m_fifo.delete(); m_half = 0; m_msb = 0; m_phase = 0; m_active = 0; m_cur = 0;
      e_mod = 8'd100; act_n = 0; pop = 0; ur = 0;
    end else begin
      bnd = pz || (m_phase == 0);
      pop = bnd && (sz > 0);
      ur  = bnd && (sz == 0) && m_active;
      sel = m_cur;
      if (pop) begin
        sel = m_fifo.pop_front();
        m_cur = sel;
      end
      act_n = pop ? 1'b1 : (bnd ? 1'b0 : m_active);
      e_mod = act_n ? qsel(sel) : 8'd100;
      if (bv && sz < 4) begin
        if (m_half) begin
          m_fifo.push_back({m_msb, bi});
          m_half = 0;
        end else begin
          m_msb = bi;
          m_half = 1;
        end
      end
      m_phase = pz ? 1 : (m_phase + 1) % 16;
      m_active = act_n;
    end
    @(posedge clk);
    #1;
    chk("mod_out", mod_out, e_mod);
    chk("mod_valid", mod_valid, act_n);
    chk("sym_start", sym_start, pop);
    chk("underrun", underrun, ur);
  endtask

  int ur_cnt;
  logic [7:0] seen [$];

  initial begin
    rst = 1; bit_valid = 0; bit_in = 0; phase_zero = 0;
    q00 = 8'd127; q01 = 8'd150; q10 = 8'd73; q11 = 8'd50;
    m_phase = 0; m_half = 0; m_msb = 0; m_active = 0; m_cur = 0;
    @(posedge clk); #1;

    // Reset then idle
    repeat (3) cycle(1, 0, 0, 0);
    chk("reset_mod_out", mod_out, 8'd100);
    chk("reset_ready", bit_ready, 1'b1);
    ur_cnt = 0;
    repeat (40) begin
      cycle(0, 0, 0, 0);
      chk("idle_mod_out", mod_out, 8'd100);
      ur_cnt += int'(underrun);
    end
    chk("idle_underrun_cnt", ur_cnt, 0);

    // Bits 1,0 then phase_zero: symbol 10 held for 16 cycles, then underrun once
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    chk("sym10_start", sym_start, 1'b1);
    chk("sym10_valid", mod_valid, 1'b1);
    chk("sym10_out", mod_out, 8'd73);
    ur_cnt = 0;
    for (int k = 1; k < 16; k++) begin
      cycle(0, 0, 0, 0);
      chk("sym10_hold", mod_out, 8'd73);
    end
    repeat (20) begin
      cycle(0, 0, 0, 0);
      ur_cnt += int'(underrun);
    end
    chk("sym10_underrun_cnt", ur_cnt, 1);
    chk("drain_mod_out", mod_out, 8'd100);

    // Eight bits back-to-back, FIFO fills, symbols out in order
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0); cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0); cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0); cycle(0, 1, 1, 0);
    chk("full_ready", bit_ready, 1'b0);
    ur_cnt = 0;
    seen.delete();
    repeat (90) begin
      cycle(0, 0, 0, 0);
      if (sym_start) seen.push_back(mod_out);
      ur_cnt += int'(underrun);
    end
    chk("order_count", seen.size(), 4);
    if (seen.size() == 4) begin
      chk("order_0", seen[0], 8'd127);
      chk("order_1", seen[1], 8'd150);
      chk("order_2", seen[2], 8'd73);
      chk("order_3", seen[3], 8'd50);
    end
    chk("fill_underrun_cnt", ur_cnt, 1);

    // phase_zero mid-period at phase_cnt = 7
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0); cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0); cycle(0, 1, 0, 0);
    while (m_phase != 7) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("pz7_start", sym_start, 1'b1);
    chk("pz7_out", mod_out, 8'd150);
    for (int k = 1; k < 16; k++) begin
      cycle(0, 0, 0, 0);
      chk("pz7_no_start", sym_start, 1'b0);
    end
    cycle(0, 0, 0, 0);
    chk("pz7_next_start", sym_start, 1'b1);
    chk("pz7_next_out", mod_out, 8'd73);

    // Reset mid bit-pair discards the half symbol
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 1);
    chk("rst_pair_out", mod_out, 8'd50);
    chk("rst_pair_start", sym_start, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      q00 = 8'($urandom); q01 = 8'($urandom); q10 = 8'($urandom); q11 = 8'($urandom);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
            1'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
